// File: rtl/vec_alu_sequencer.sv
// vec_alu_sequencer: walks a vector add/mul command one element at a time.
// For each element it reads the operand pair from the register file, issues it
// to the FP ALU, waits for alu_ready and writes the result back.
// Optional build macro: VSEQ_TIMEOUT_EN adds a WAIT watchdog that aborts the
// command with a one-cycle err pulse after TIMEOUT cycles without alu_ready.
module vec_alu_sequencer #(
    parameter int VLEN    = 8,
    parameter int DW      = 32,
    parameter int TIMEOUT = 64
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    cmd_valid,
    output logic                    cmd_ready,
    input  logic                    cmd_func,
    input  logic [$clog2(VLEN):0]   cmd_len,
    output logic                    rd_en,
    output logic [$clog2(VLEN)-1:0] rd_addr,
    input  logic [DW-1:0]           rd_data_a,
    input  logic [DW-1:0]           rd_data_b,
    output logic [DW-1:0]           alu_a,
    output logic [DW-1:0]           alu_b,
    output logic                    alu_func,
    output logic                    alu_start,
    input  logic                    alu_ready,
    input  logic                    alu_busy,
    input  logic [DW-1:0]           alu_result,
    output logic                    wr_en,
    output logic [$clog2(VLEN)-1:0] wr_addr,
    output logic [DW-1:0]           wr_data,
    output logic                    done,
    output logic                    err
);

    localparam int AW = $clog2(VLEN);
    localparam int IW = AW + 1;
    localparam logic [IW-1:0] VLEN_L = IW'(VLEN);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_FETCH,
        ST_ISSUE,
        ST_WAIT,
        ST_WRITE,
        ST_DONE
    } state_t;

    state_t        state;
    state_t        state_nx;

    logic          func_q;
    logic [IW-1:0] len_q;
    logic [IW-1:0] idx;
    logic [IW-1:0] len_sat;
    logic          last_elem;
    logic          opnd_pend;
    logic [DW-1:0] a_q;
    logic [DW-1:0] b_q;
    logic [DW-1:0] res_q;
    logic          wd_expire;

    assign len_sat   = (cmd_len > VLEN_L) ? VLEN_L : cmd_len;
    assign last_elem = (idx == len_q - 1'b1);

`ifdef VSEQ_TIMEOUT_EN
    localparam int WCW = $clog2(TIMEOUT + 1);
    localparam logic [WCW-1:0] WD_LAST = WCW'(TIMEOUT - 1);

    logic [WCW-1:0] wd_cnt;

    // Watchdog: cleared by each issue, counts every cycle spent in WAIT
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wd_cnt <= '0;
        end else if (alu_start) begin
            wd_cnt <= '0;
        end else if (state == ST_WAIT) begin
            wd_cnt <= wd_cnt + 1'b1;
        end
    end

    // Expiry fires on the TIMEOUT-th WAIT cycle; a result arriving that same cycle wins
    assign wd_expire = (state == ST_WAIT) && !alu_ready && (wd_cnt == WD_LAST);
`else
    assign wd_expire = 1'b0;
`endif

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nx;
        end
    end

    // Next-state decode
    always_comb begin
        state_nx = state;
        unique case (state)
            ST_IDLE: begin
                if (cmd_valid) begin
                    state_nx = (len_sat == '0) ? ST_DONE : ST_FETCH;
                end
            end
            ST_FETCH: state_nx = ST_ISSUE;
            ST_ISSUE: begin
                if (!alu_busy) begin
                    state_nx = ST_WAIT;
                end
            end
            ST_WAIT: begin
                if (alu_ready) begin
                    state_nx = ST_WRITE;
                end else if (wd_expire) begin
                    state_nx = ST_IDLE;
                end
            end
            ST_WRITE: state_nx = last_elem ? ST_DONE : ST_FETCH;
            ST_DONE:  state_nx = ST_IDLE;
            default:  state_nx = ST_IDLE;
        endcase
    end

    // Output decode
    always_comb begin
        cmd_ready = 1'b0;
        rd_en     = 1'b0;
        alu_start = 1'b0;
        wr_en     = 1'b0;
        done      = 1'b0;
        unique case (state)
            ST_IDLE:  cmd_ready = 1'b1;
            ST_FETCH: rd_en     = 1'b1;
            ST_ISSUE: alu_start = !alu_busy;
            ST_WRITE: wr_en     = 1'b1;
            ST_DONE:  done      = 1'b1;
            default:  ;
        endcase
    end

    // Command latch, element index, operand capture and result register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            func_q    <= 1'b0;
            len_q     <= '0;
            idx       <= '0;
            opnd_pend <= 1'b0;
            a_q       <= '0;
            b_q       <= '0;
            res_q     <= '0;
        end else begin
            if (state == ST_IDLE && cmd_valid) begin
                func_q <= cmd_func;
                len_q  <= len_sat;
                idx    <= '0;
            end
            if (state == ST_WRITE && !last_elem) begin
                idx <= idx + 1'b1;
            end
            opnd_pend <= (state == ST_FETCH);
            if (opnd_pend) begin
                a_q <= rd_data_a;
                b_q <= rd_data_b;
            end
            if (state == ST_WAIT && alu_ready) begin
                res_q <= alu_result;
            end
        end
    end

    // Read data arrives during the first ISSUE cycle; it is forwarded straight
    // to the ALU then and served from a_q/b_q for busy stalls and WAIT.
    assign alu_a    = opnd_pend ? rd_data_a : a_q;
    assign alu_b    = opnd_pend ? rd_data_b : b_q;
    assign alu_func = func_q;
    assign rd_addr  = idx[AW-1:0];
    assign wr_addr  = idx[AW-1:0];
    assign wr_data  = res_q;
    assign err      = wd_expire;

endmodule

// File: tb/tb_vec_alu_sequencer.sv
// Directed bench for vec_alu_sequencer with a registered-read register-file
// model, a variable-latency ALU model and a write-back scoreboard.
module tb_vec_alu_sequencer;

    localparam int VLEN    = 8;
    localparam int DW      = 32;
    localparam int TIMEOUT = 64;
    localparam int AW      = 3;
    localparam int IW      = 4;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          cmd_valid = 1'b0;
    logic          cmd_ready;
    logic          cmd_func = 1'b0;
    logic [IW-1:0] cmd_len = '0;
    logic          rd_en;
    logic [AW-1:0] rd_addr;
    logic [DW-1:0] rd_data_a;
    logic [DW-1:0] rd_data_b;
    logic [DW-1:0] alu_a;
    logic [DW-1:0] alu_b;
    logic          alu_func;
    logic          alu_start;
    logic          alu_ready;
    logic          alu_busy;
    logic [DW-1:0] alu_result;
    logic          wr_en;
    logic [AW-1:0] wr_addr;
    logic [DW-1:0] wr_data;
    logic          done;
    logic          err;

    always #5 clk = ~clk;

    vec_alu_sequencer #(.VLEN(VLEN), .DW(DW), .TIMEOUT(TIMEOUT)) dut (
        .clk(clk), .rst_n(rst_n),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_func(cmd_func), .cmd_len(cmd_len),
        .rd_en(rd_en), .rd_addr(rd_addr), .rd_data_a(rd_data_a), .rd_data_b(rd_data_b),
        .alu_a(alu_a), .alu_b(alu_b), .alu_func(alu_func), .alu_start(alu_start),
        .alu_ready(alu_ready), .alu_busy(alu_busy), .alu_result(alu_result),
        .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
        .done(done), .err(err)
    );

    typedef struct {
        logic [AW-1:0] addr;
        logic [DW-1:0] data;
        logic          func;
    } exp_t;

    exp_t          sb[$];
    int            errors = 0;
    int            checks = 0;
    int            cyc = 0;
    int            n_rd = 0, n_start = 0, n_wr = 0, n_done = 0, n_err = 0;
    int            start_cyc = 0, done_cyc = 0, err_cyc = 0;
    logic [DW-1:0] ra [VLEN];
    logic [DW-1:0] rb [VLEN];
    int            alu_lat = 1;
    bit            alu_hang = 1'b0;
    bit            busy_mode = 1'b0;

    // Reference ALU: exact IEEE results for the known vectors, integer stand-ins otherwise
    function automatic logic [DW-1:0] alu_fn(input logic f, input logic [DW-1:0] a, input logic [DW-1:0] b);
        if (!f && a == 32'h3FC0_0000 && b == 32'h4010_0000) return 32'h4070_0000;
        if (f && a == 32'h4000_0000 && b == 32'h4040_0000) return 32'h40C0_0000;
        return f ? a * b : a + b;
    endfunction

    function automatic void push_cmd(input logic f, input int len);
        int n;
        n = (len > VLEN) ? VLEN : len;
        for (int i = 0; i < n; i++) begin
            sb.push_back('{addr: AW'(i), data: alu_fn(f, ra[i], rb[i]), func: f});
        end
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    always @(posedge clk) cyc <= cyc + 1;

    // Register file: data valid one cycle after rd_en, junk otherwise
    initial forever begin
        @(posedge clk or negedge rst_n);
        if (!rst_n) begin
            rd_data_a <= '0;
            rd_data_b <= '0;
        end else if (rd_en) begin
            rd_data_a <= ra[rd_addr];
            rd_data_b <= rb[rd_addr];
        end else begin
            rd_data_a <= 32'hDEAD_BEEF;
            rd_data_b <= 32'hFEED_F00D;
        end
    end

    // ALU: alu_ready alu_lat cycles after alu_start, busy pattern on request
    logic [DW-1:0] op_a, op_b;
    logic          op_f;
    int            alu_cnt;
    initial forever begin
        @(posedge clk or negedge rst_n);
        if (!rst_n) begin
            alu_cnt    <= 0;
            alu_ready  <= 1'b0;
            alu_busy   <= 1'b0;
            alu_result <= '0;
        end else begin
            alu_ready  <= 1'b0;
            alu_result <= 32'hBAD0_0000;
            alu_busy   <= busy_mode && (cyc % 3 != 0);
            if (alu_start) begin
                op_a <= alu_a;
                op_b <= alu_b;
                op_f <= alu_func;
                if (alu_hang) begin
                    alu_cnt <= 0;
                end else if (alu_lat == 1) begin
                    alu_ready  <= 1'b1;
                    alu_result <= alu_fn(alu_func, alu_a, alu_b);
                end else begin
                    alu_cnt <= alu_lat - 1;
                end
            end else if (alu_cnt > 0) begin
                if (alu_cnt == 1) begin
                    alu_ready  <= 1'b1;
                    alu_result <= alu_fn(op_f, op_a, op_b);
                end
                alu_cnt <= alu_cnt - 1;
            end
        end
    end

    // Monitor: event counters, operand checks at issue/result, scoreboard at write-back
    initial forever begin
        @(negedge clk);
        if (rd_en) n_rd++;
        if (done) begin n_done++; done_cyc = cyc; end
        if (err) begin n_err++; err_cyc = cyc; end
        if (alu_start) begin
            n_start++;
            start_cyc = cyc;
            chk("start_while_busy", 32'(alu_busy), 0);
            chk("start_expected", 32'(sb.size() > 0), 1);
            if (sb.size() > 0) begin
                chk("alu_a", alu_a, ra[sb[0].addr]);
                chk("alu_b", alu_b, rb[sb[0].addr]);
                chk("alu_func", 32'(alu_func), 32'(sb[0].func));
            end
        end
        if (alu_ready && sb.size() > 0) begin
            chk("alu_a_hold", alu_a, ra[sb[0].addr]);
            chk("alu_b_hold", alu_b, rb[sb[0].addr]);
        end
        if (wr_en) begin
            n_wr++;
            chk("wr_expected", 32'(sb.size() > 0), 1);
            if (sb.size() > 0) begin
                exp_t e;
                e = sb.pop_front();
                chk("wr_addr", 32'(wr_addr), 32'(e.addr));
                chk("wr_data", wr_data, e.data);
            end
        end
    end

    task automatic chk_reset(input string t);
        chk({t, "_cmd_ready"}, 32'(cmd_ready), 1);
        chk({t, "_rd_en"}, 32'(rd_en), 0);
        chk({t, "_rd_addr"}, 32'(rd_addr), 0);
        chk({t, "_alu_a"}, alu_a, 0);
        chk({t, "_alu_b"}, alu_b, 0);
        chk({t, "_alu_func"}, 32'(alu_func), 0);
        chk({t, "_alu_start"}, 32'(alu_start), 0);
        chk({t, "_wr_en"}, 32'(wr_en), 0);
        chk({t, "_wr_addr"}, 32'(wr_addr), 0);
        chk({t, "_wr_data"}, wr_data, 0);
        chk({t, "_done"}, 32'(done), 0);
        chk({t, "_err"}, 32'(err), 0);
    endtask

    // Present a command and hold it until accepted; acc is the accepting cycle
    task automatic send(input string t, input logic f, input logic [IW-1:0] len, output int acc);
        bit got;
        got = 1'b0;
        acc = 0;
        @(posedge clk); #1;
        cmd_valid = 1'b1;
        cmd_func  = f;
        cmd_len   = len;
        for (int i = 0; i < 200 && !got; i++) begin
            @(negedge clk);
            if (cmd_ready) begin got = 1'b1; acc = cyc; end
        end
        chk({t, "_accepted"}, 32'(got), 1);
        @(posedge clk); #1;
        cmd_valid = 1'b0;
        if (got) push_cmd(f, int'(len));
    endtask

    // Wait for done; rdy_hi counts cycles in which cmd_ready was seen while busy
    task automatic wait_done(input string t, input int budget, output int rdy_hi);
        int d0;
        bit seen;
        d0 = n_done;
        seen = 1'b0;
        rdy_hi = 0;
        for (int i = 0; i < budget && !seen; i++) begin
            @(negedge clk); #1;
            if (n_done != d0) seen = 1'b1;
            else if (cmd_ready) rdy_hi++;
        end
        chk({t, "_done_seen"}, 32'(seen), 1);
    endtask

    initial begin
        int acc, acc2, rdy, w0, s0, r0, d0;
        bit got;

        // Reset state
        #2;
        chk_reset("rst");
        repeat (2) @(negedge clk);
        rst_n = 1'b1;

        // 1: add, len 1, L=4
        ra[0] = 32'h3FC0_0000; rb[0] = 32'h4010_0000;
        alu_lat = 4;
        w0 = n_wr;
        send("t1", 1'b0, 4'd1, acc);
        wait_done("t1", 100, rdy);
        chk("t1_latency", 32'(done_cyc - acc + 1), 9);
        chk("t1_writes", 32'(n_wr - w0), 1);
        chk("t1_sb_empty", 32'(sb.size()), 0);
        chk("t1_ready_busy", 32'(rdy), 0);

        // 2: mul, len VLEN, L=1
        for (int i = 0; i < VLEN; i++) begin ra[i] = 32'h4000_0000; rb[i] = 32'h4040_0000; end
        alu_lat = 1;
        w0 = n_wr; s0 = n_start; r0 = n_rd; d0 = n_done;
        send("t2", 1'b1, 4'd8, acc);
        wait_done("t2", 200, rdy);
        chk("t2_latency", 32'(done_cyc - acc + 1), 8 * (1 + 3) + 2);
        chk("t2_writes", 32'(n_wr - w0), 8);
        chk("t2_starts", 32'(n_start - s0), 8);
        chk("t2_reads", 32'(n_rd - r0), 8);
        chk("t2_dones", 32'(n_done - d0), 1);
        chk("t2_sb_empty", 32'(sb.size()), 0);

        // 3: len 0 completes without any element traffic
        w0 = n_wr; s0 = n_start; r0 = n_rd;
        send("t3", 1'b0, 4'd0, acc);
        wait_done("t3", 20, rdy);
        chk("t3_latency", 32'(done_cyc - acc), 1);
        chk("t3_reads", 32'(n_rd - r0), 0);
        chk("t3_starts", 32'(n_start - s0), 0);
        chk("t3_writes", 32'(n_wr - w0), 0);

        // 4: cmd_valid held through a command; next command only after done
        for (int i = 0; i < VLEN; i++) begin ra[i] = 32'(100 + i); rb[i] = 32'(7 * i + 3); end
        alu_lat = 2;
        w0 = n_wr; d0 = n_done;
        @(posedge clk); #1;
        cmd_valid = 1'b1; cmd_func = 1'b0; cmd_len = 4'd2;
        @(negedge clk);
        chk("t4_first_ready", 32'(cmd_ready), 1);
        @(posedge clk); #1;
        push_cmd(1'b0, 2);
        cmd_func = 1'b1; cmd_len = 4'd3;
        wait_done("t4a", 100, rdy);
        chk("t4a_ready_busy", 32'(rdy), 0);
        @(negedge clk);
        chk("t4_second_ready", 32'(cmd_ready), 1);
        acc2 = cyc;
        @(posedge clk); #1;
        push_cmd(1'b1, 3);
        cmd_valid = 1'b0;
        wait_done("t4b", 100, rdy);
        chk("t4b_ready_busy", 32'(rdy), 0);
        chk("t4b_latency", 32'(done_cyc - acc2 + 1), 3 * (2 + 3) + 2);
        chk("t4_writes", 32'(n_wr - w0), 5);
        chk("t4_dones", 32'(n_done - d0), 2);
        chk("t4_sb_empty", 32'(sb.size()), 0);

        // Oversized len saturates to VLEN
        for (int i = 0; i < VLEN; i++) begin ra[i] = 32'(i * 3 + 1); rb[i] = 32'(i + 50); end
        alu_lat = 1;
        w0 = n_wr;
        send("sat", 1'b0, 4'd15, acc);
        wait_done("sat", 200, rdy);
        chk("sat_writes", 32'(n_wr - w0), 8);
        chk("sat_sb_empty", 32'(sb.size()), 0);

        // ALU busy stalls the issue
        for (int i = 0; i < VLEN; i++) begin ra[i] = 32'(i + 11); rb[i] = 32'(i + 5); end
        busy_mode = 1'b1;
        alu_lat = 3;
        w0 = n_wr; s0 = n_start;
        send("busy", 1'b1, 4'd3, acc);
        wait_done("busy", 200, rdy);
        busy_mode = 1'b0;
        chk("busy_writes", 32'(n_wr - w0), 3);
        chk("busy_starts", 32'(n_start - s0), 3);
        chk("busy_sb_empty", 32'(sb.size()), 0);

        // 5: reset during WAIT of element 3
        for (int i = 0; i < VLEN; i++) begin ra[i] = 32'(i + 200); rb[i] = 32'(i * 9); end
        alu_lat = 10;
        w0 = n_wr; s0 = n_start;
        send("t5", 1'b1, 4'd6, acc);
        got = 1'b0;
        for (int i = 0; i < 200 && !got; i++) begin
            @(negedge clk);
            if (n_start == s0 + 4) got = 1'b1;
        end
        chk("t5_reached_elem3", 32'(got), 1);
        repeat (3) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk_reset("t5");
        chk("t5_partial_writes", 32'(n_wr - w0), 3);
        sb.delete();
        d0 = n_done;
        repeat (2) @(negedge clk);
        #2 rst_n = 1'b1;
        repeat (20) @(negedge clk);
        chk("t5_no_done", 32'(n_done - d0), 0);
        for (int i = 0; i < VLEN; i++) begin ra[i] = 32'(i + 300); rb[i] = 32'(i + 400); end
        alu_lat = 2;
        w0 = n_wr;
        send("t5r", 1'b0, 4'd2, acc);
        wait_done("t5r", 100, rdy);
        chk("t5r_writes", 32'(n_wr - w0), 2);
        chk("t5r_sb_empty", 32'(sb.size()), 0);

`ifdef VSEQ_TIMEOUT_EN
        // 6: ALU never answers, watchdog aborts the command
        alu_hang = 1'b1;
        w0 = n_wr; d0 = n_done; r0 = n_err;
        send("t6", 1'b1, 4'd2, acc);
        got = 1'b0;
        for (int i = 0; i < 200 && !got; i++) begin
            @(negedge clk); #1;
            if (n_err != r0) got = 1'b1;
        end
        chk("t6_err_seen", 32'(got), 1);
        chk("t6_err_delay", 32'(err_cyc - start_cyc), TIMEOUT);
        chk("t6_no_write", 32'(n_wr - w0), 0);
        @(negedge clk);
        chk("t6_cmd_ready", 32'(cmd_ready), 1);
        chk("t6_no_done", 32'(n_done - d0), 0);
        alu_hang = 1'b0;
        sb.delete();
`else
        chk("no_err_pulses", 32'(n_err), 0);
`endif

        repeat (5) @(negedge clk);
        chk("final_sb_empty", 32'(sb.size()), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
